// File: rtl/bus_receive_buffer_16bit_pkg.sv
// Shared bus constants for the receive buffer and the transfer-gate modules.
// Also provides a small helper for sizing the occupancy counter.
package bus_receive_buffer_16bit_pkg;

    localparam int BUS_WIDTH        = 16;
    localparam int DEFAULT_RX_DEPTH = 4;

    // Width of a counter that must hold values from 0 to depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bus_rx_storage.sv
// DEPTH x WIDTH register array for the bus receive FIFO.
// Synchronous write, combinational read, every entry cleared on reset.
module bus_rx_storage
    import bus_receive_buffer_16bit_pkg::*;
#(
    parameter int WIDTH = BUS_WIDTH,
    parameter int DEPTH = DEFAULT_RX_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bus_receive_buffer_16bit.sv
// Receive end of the shared tri-state bus: captures the bus on load into a FIFO
// and hands words to a local consumer in capture order, with status for throttling.
module bus_receive_buffer_16bit
    import bus_receive_buffer_16bit_pkg::*;
#(
    parameter int WIDTH = BUS_WIDTH,
    parameter int DEPTH = DEFAULT_RX_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         bus_data,
    input  logic                     load,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     clear_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Handshake: a word transfers on any edge where out_valid && out_ready;
    // out_data is held stable while out_valid is high and out_ready is low,
    // and out_ready without out_valid has no effect.
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push      = load && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A dropped load takes priority over a clear in the same cycle.
            if (load && !push) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    bus_rx_storage #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_storage (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus_data),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

endmodule

// File: tb/tb_bus_receive_buffer_16bit.sv
// Self-checking bench for bus_receive_buffer_16bit against a queue-based
// reference model of the receive FIFO.
module tb_bus_receive_buffer_16bit;

    localparam int W = 16;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  bus_data;
    logic          load;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    count;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          clear_ovf;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic         exp_ovf;

    bus_receive_buffer_16bit #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_data  (bus_data),
        .load      (load),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .clear_ovf (clear_ovf)
    );

    always #5 clk = ~clk;

    // Advance one clock edge; the reference model follows the FIFO rules:
    // a word leaves when the queue is non-empty and the consumer is ready,
    // a word enters on load if there is room (counting the word leaving).
    task automatic tick();
        bit do_pop;
        bit do_push;
        @(posedge clk);
        do_pop  = (exp_q.size() > 0) && out_ready;
        do_push = load && ((exp_q.size() < D) || do_pop);
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(bus_data);
        if (load && !do_push) exp_ovf = 1'b1;
        else if (clear_ovf) exp_ovf = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0; bus_data = 'z;
        exp_q.delete(); exp_ovf = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", empty); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_data got %h want 0000", out_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", overflow); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", full); end
    endtask

    task automatic test_single();
        bus_data = 16'hA55A; load = 1'b1; out_ready = 1'b0;
        tick();
        load = 1'b0; bus_data = 'z;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", out_valid); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", count); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_data !== 16'hA55A) begin errors++; $display("FAIL single_hold%0d got %h want a55a", i, out_data); end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty got %0b want 1", empty); end
    endtask

    task automatic test_fill_overflow();
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            bus_data = W'(i); load = 1'b1;
            tick();
            if (i == 4) begin
                checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %0b want 1", full); end
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_noovf got %0b want 0", overflow); end
            end
        end
        load = 1'b0; bus_data = 'z;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_ovf got %0b want 1", overflow); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", count); end
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            checks++; if (out_data !== W'(k) || out_valid !== 1'b1) begin errors++; $display("FAIL drain%0d got %h/%0b want %h/1", k, out_data, out_valid, W'(k)); end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %0b want 1", empty); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b want 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [W-1:0] want[4];
        want[0] = 16'h0002; want[1] = 16'h0003; want[2] = 16'h0004; want[3] = 16'hBEEF;
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            bus_data = W'(i); load = 1'b1;
            tick();
        end
        bus_data = 16'hBEEF; load = 1'b1; out_ready = 1'b1;
        checks++; if (out_data !== 16'h0001) begin errors++; $display("FAIL fpp_head got %h want 0001", out_data); end
        tick();
        load = 1'b0; bus_data = 'z;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fpp_count got %0d want 4", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf got %0b want 0", overflow); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (out_data !== want[k] || out_valid !== 1'b1) begin errors++; $display("FAIL fpp_drain%0d got %h want %h", k, out_data, want[k]); end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fpp_empty got %0b want 1", empty); end
    endtask

    task automatic test_wrap();
        int delivered;
        delivered = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 21; i++) begin
            if (i < 20) begin bus_data = 16'h1000 + W'(i); load = 1'b1; end
            else begin bus_data = 'z; load = 1'b0; end
            if (out_valid) begin
                checks++; if (out_data !== 16'h1000 + W'(delivered)) begin errors++; $display("FAIL wrap_data%0d got %h want %h", delivered, out_data, 16'h1000 + W'(delivered)); end
                delivered++;
            end
            tick();
            checks++; if (count > 3'd1) begin errors++; $display("FAIL wrap_count%0d got %0d want <=1", i, count); end
        end
        out_ready = 1'b0;
        checks++; if (delivered != 20 || empty !== 1'b1) begin errors++; $display("FAIL wrap_total got %0d/%0b want 20/1", delivered, empty); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus_data = 16'h7700 + W'(i); load = 1'b1;
            tick();
        end
        load = 1'b0; bus_data = 'z;
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete(); exp_ovf = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %0b want 0", out_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL arst_count got %0d want 0", count); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL arst_data got %h want 0000", out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus_data = 16'hC0D0 + W'(i); load = 1'b1;
            tick();
        end
        load = 1'b0; bus_data = 'z; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (out_data !== 16'hC0D0 + W'(i) || out_valid !== 1'b1) begin errors++; $display("FAIL arst_post%0d got %h want %h", i, out_data, 16'hC0D0 + W'(i)); end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL arst_empty got %0b want 1", empty); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            load      = ($urandom_range(0, 99) < 55);
            bus_data  = load ? W'($urandom) : 'z;
            out_ready = ($urandom_range(0, 99) < 45);
            clear_ovf = ($urandom_range(0, 99) < 8);
            tick();
            checks++;
            if (count !== 3'(exp_q.size()) || out_valid !== (exp_q.size() > 0) ||
                full !== (exp_q.size() == D) || empty !== (exp_q.size() == 0) ||
                overflow !== exp_ovf ||
                (exp_q.size() > 0 && out_data !== exp_q[0])) begin
                errors++;
                $display("FAIL rand%0d got cnt=%0d v=%0b f=%0b e=%0b o=%0b d=%h want cnt=%0d o=%0b d=%h",
                         n, count, out_valid, full, empty, overflow, out_data,
                         exp_q.size(), exp_ovf, (exp_q.size() > 0) ? exp_q[0] : 16'h0000);
            end
        end
        load = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0; bus_data = 'z;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_push_pop();
        test_wrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_receive_buffer_16bit.md
Name: bus_receive_buffer_16bit

Overview:
- Receiving end of the shared 16-bit tri-state data bus. The bus controller asserts a 16-bit transfer gate's enable; in that same cycle it asserts this block's load.
- The block samples the resolved bus value on that strobe and queues it in a small FIFO.
- The queued word is presented to a local consumer over a valid/ready handshake.
- Status flags (count, full, empty, sticky overflow) go back to the bus controller so it can throttle transfers.

Parameters:
- WIDTH, 16: bus and data width in bits.
- DEPTH, 4: number of FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clk, input, 1: system clock. All state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- bus_data, input, WIDTH: resolved value of the shared tri-state bus.
- load, input, 1: capture strobe. Asserted in the cycle a transmitter drives bus_data.
- out_data, output, WIDTH: head-of-FIFO word (first-word fall-through).
- out_valid, output, 1: out_data holds a valid entry.
- out_ready, input, 1: consumer accepts out_data this cycle.
- count, output, $clog2(DEPTH)+1: number of occupied entries, 0..DEPTH.
- full, output, 1: count == DEPTH.
- empty, output, 1: count == 0.
- overflow, output, 1: sticky flag; a load was dropped.
- clear_ovf, input, 1: synchronous clear of overflow.

Behaviour:
- Reset (rst_n low, asynchronous):
  - write pointer, read pointer, count and overflow = 0.
  - All storage entries = 0, so out_data = 0.
  - out_valid = 0, full = 0, empty = 1.
- Internal events:
  - pop = out_valid && out_ready.
  - push = load && (!full || pop).
- bus_data is sampled only at an edge where push = 1. bus_data is ignored otherwise, including X/Z while the bus floats.
- Push: storage[wr_ptr] <= bus_data; wr_ptr increments modulo DEPTH.
- Pop: rd_ptr increments modulo DEPTH.
- Count update: count <= count + push − pop. All flags derive from the registered count, so they are glitch-free.
- out_data = storage[rd_ptr], combinational from registers.
- out_valid = !empty.
- Latency: a load at edge N gives out_valid = 1 and out_data = the captured word in the cycle after edge N. There is no bypass from bus_data to out_data in the same cycle.
- Ordering: words are delivered strictly in capture order.
- Handshake rules:
  - out_data must remain stable while out_valid = 1 and out_ready = 0.
  - out_ready with out_valid = 0 has no effect.
- Full, with load and pop in the same cycle: accepted. Count stays at DEPTH and both pointers advance.
- Full, load and no pop: the word is dropped, storage and pointers are unchanged, and overflow <= 1.
- Empty, load and out_ready in the same cycle: no pop, because out_valid = 0. The word is pushed and appears next cycle.
- overflow stays set until clear_ovf. If a drop and clear_ovf occur in the same cycle, set wins (overflow stays 1).
- Pointer wrap-around: natural binary wrap. count distinguishes full from empty when wr_ptr == rd_ptr.
- Reset mid-operation: all queued words are discarded immediately and outputs return to their reset values without waiting for a clock edge.

Decomposition:
- Shared package/include holds BUS_WIDTH = 16 and DEFAULT_RX_DEPTH = 4, common with the transfer-gate modules.
- Sub-module bus_rx_storage: DEPTH x WIDTH register array.
  - Ports: clk, rst_n, we, waddr, wdata, raddr, rdata.
  - Synchronous write, asynchronous reset to 0, combinational read.
- Pointers, count, flags and handshake logic stay in the top module.

Test Plan:
- Reset release: after reset, with no load → out_valid = 0, empty = 1, count = 0, out_data = 16'h0000, overflow = 0.
- Single transfer: bus_data = 16'hA55A with load for 1 cycle, out_ready = 0 → next cycle out_valid = 1, out_data = 16'hA55A, count = 1; data stays held over 3 stall cycles; out_ready = 1 pops it → empty = 1.
- Fill and overflow: load 16'h0001..16'h0005 on consecutive cycles with out_ready = 0 → full = 1 after the 4th word and overflow = 1 after the 5th. Draining yields 0001, 0002, 0003, 0004; 0005 is lost. clear_ovf then gives overflow = 0.
- Full with simultaneous push and pop: FIFO full of 0001..0004; load 16'hBEEF with out_ready = 1 → 0001 is consumed, count stays 4, overflow stays 0, and the drain order is 0002, 0003, 0004, BEEF.
- Wrap-around streaming: 20 words 16'h1000+i loaded every cycle with out_ready = 1 → every word is delivered in order, count is never above 1, and the pointers wrap multiple times.
- Asynchronous reset mid-operation: 3 words queued, rst_n pulsed low between clock edges → out_valid = 0 and count = 0 immediately; words loaded after rst_n rises are delivered correctly.
